// File: rtl/data_mem.sv
// Data RAM behind the processor memory stage. Merges bytes for word, SWL and
// SWR stores, clears itself after reset and has a registered debug read port.
module data_mem #(
    parameter int DEPTH_WORDS    = 16384,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] MemAddr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        WriteL,
    input  logic        WriteR,
    output logic [31:0] MemData,
    input  logic [15:0] DbgAddr,
    output logic [31:0] DbgData,
    output logic        Busy,
    output logic        StoreErr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          store_err_q, store_err_d;
    logic [31:0]   mem_data_q;
    logic [31:0]   dbg_data_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] acc_idx;
    logic [AW-1:0] dbg_idx;
    logic [1:0]    ofs;
    logic [1:0]    swr_sh;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;

    assign acc_idx = MemAddr[AW+1:2];
    assign dbg_idx = DbgAddr[AW+1:2];
    assign ofs     = MemAddr[1:0];
    assign swr_sh  = 2'd3 - ofs;

    // Byte offsets of the debug address and high bits beyond the RAM depth never matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{DbgAddr[1:0], DbgAddr[15:AW+2], MemAddr[15:AW+2]};

    // wr_be bit i enables bits [8i+7:8i]; lane 0 (MSB byte) is wr_be[3].
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_err_d = store_err_q;
        wr_idx      = acc_idx;
        wr_data     = WriteData;
        wr_be       = 4'b0000;
        rd_en       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_idx  = cnt_q;
                wr_data = 32'h0;
                wr_be   = 4'b1111;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                rd_en = MemRead;
                if (MemWrite) begin
                    case ({WriteL, WriteR})
                        2'b00: wr_be = 4'b1111;
                        2'b10: begin
                            wr_data = WriteData >> {ofs, 3'b000};
                            wr_be   = 4'b1111 >> ofs;
                        end
                        2'b01: begin
                            wr_data = WriteData << {swr_sh, 3'b000};
                            wr_be   = 4'b1111 << swr_sh;
                        end
                        default: store_err_d = 1'b1;
                    endcase
                end
            end
        endcase
        if (!nReset) begin
            wr_be = 4'b0000;
        end
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            busy_q      <= CLEAR_ON_RESET;
            cnt_q       <= '0;
            store_err_q <= 1'b0;
            mem_data_q  <= 32'h0;
            dbg_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            store_err_q <= store_err_d;
            if (rd_en) begin
                mem_data_q <= mem[acc_idx];
            end
            dbg_data_q <= mem[dbg_idx];
        end
    end

    // Reads above see the pre-write word when the same index is written this cycle.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign MemData  = mem_data_q;
    assign DbgData  = dbg_data_q;
    assign Busy     = busy_q;
    assign StoreErr = store_err_q;
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem with a 16-word array and clear-on-reset enabled.
module tb_data_mem;
    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] MemAddr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        WriteL = 1'b0;
    logic        WriteR = 1'b0;
    logic [31:0] MemData;
    logic [15:0] DbgAddr = '0;
    logic [31:0] DbgData;
    logic        Busy;
    logic        StoreErr;

    data_mem #(.DEPTH_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
        .Clock(Clock), .nReset(nReset), .MemAddr(MemAddr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .WriteL(WriteL), .WriteR(WriteR),
        .MemData(MemData), .DbgAddr(DbgAddr), .DbgData(DbgData), .Busy(Busy),
        .StoreErr(StoreErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: a load accepted at an edge is compared on the following negedge.
    always @(posedge Clock) rd_pend <= nReset && MemRead && !Busy;

    always @(negedge Clock) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got %h expected none", MemData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, MemData, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [15:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        MemAddr = addr;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
    endtask

    task automatic store(input logic [15:0] addr, input logic [31:0] data,
                         input logic l, input logic r);
        MemAddr   = addr;
        WriteData = data;
        WriteL    = l;
        WriteR    = r;
        MemWrite  = 1'b1;
        tick();
        MemWrite = 1'b0;
        WriteL   = 1'b0;
        WriteR   = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int cycles = 0;
        while (Busy && cycles < 40) begin
            tick();
            cycles++;
        end
        chk(name, 32'(cycles), 32'd16);
    endtask

    initial begin
        int cycles;
        tick();
        tick();
        chk("rst_memdata", MemData, 32'h0);
        chk("rst_dbgdata", DbgData, 32'h0);
        chk("rst_storeerr", {31'h0, StoreErr}, 32'h0);
        chk("rst_busy", {31'h0, Busy}, 32'h1);

        // Clear sequence; a store+load attempted in the last busy cycle is dropped.
        nReset = 1'b1;
        cycles = 0;
        while (Busy && cycles < 40) begin
            if (cycles == 15) begin
                MemAddr = 16'h0004; WriteData = 32'hFFFF_FFFF;
                MemWrite = 1'b1; MemRead = 1'b1;
            end
            tick();
            cycles++;
        end
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("clear_len", 32'(cycles), 32'd16);
        chk("busy_memdata_held", MemData, 32'h0);

        load(16'h0008, 32'h0000_0000, "load_cleared");
        load(16'h0004, 32'h0000_0000, "busy_store_dropped");

        store(16'h0004, 32'h1122_3344, 1'b0, 1'b0);
        load(16'h0006, 32'h1122_3344, "full_store");
        MemAddr = 16'h0008;
        tick(); tick(); tick();
        chk("memdata_hold", MemData, 32'h1122_3344);

        store(16'h0010, 32'hAABB_CCDD, 1'b0, 1'b0);
        store(16'h0011, 32'h1122_3344, 1'b1, 1'b0);
        load(16'h0010, 32'hAA11_2233, "swl_o1");
        store(16'h0012, 32'h5566_7788, 1'b0, 1'b1);
        load(16'h0012, 32'h6677_8833, "swr_o2");

        store(16'h0014, 32'h0102_0304, 1'b0, 1'b0);
        store(16'h0017, 32'hA1B2_C3D4, 1'b1, 1'b0);
        load(16'h0014, 32'h0102_03A1, "swl_o3");
        store(16'h0014, 32'hA1B2_C3D4, 1'b0, 1'b1);
        load(16'h0014, 32'hD402_03A1, "swr_o0");

        // Same-cycle store and load: read-before-write on both ports.
        store(16'h0020, 32'h0000_0005, 1'b0, 1'b0);
        begin
            exp_t e;
            e.name = "rbw_load";
            e.val  = 32'h0000_0005;
            exp_q.push_back(e);
        end
        MemAddr = 16'h0020; WriteData = 32'hDEAD_BEEF; DbgAddr = 16'h0020;
        MemWrite = 1'b1; MemRead = 1'b1;
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("rbw_dbg", DbgData, 32'h0000_0005);
        load(16'h0020, 32'hDEAD_BEEF, "after_rbw");
        chk("dbg_new", DbgData, 32'hDEAD_BEEF);

        // Illegal store handling.
        store(16'h0030, 32'h1234_5678, 1'b0, 1'b0);
        WriteL = 1'b1; WriteR = 1'b1;
        tick();
        WriteL = 1'b0; WriteR = 1'b0;
        chk("lr_no_write_no_err", {31'h0, StoreErr}, 32'h0);
        store(16'h0030, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("illegal_sets_err", {31'h0, StoreErr}, 32'h1);
        load(16'h0030, 32'h1234_5678, "illegal_no_write");
        store(16'h0034, 32'h0000_0001, 1'b0, 1'b0);
        chk("err_sticky", {31'h0, StoreErr}, 32'h1);

        // Reset during clear restarts the full sequence.
        nReset = 1'b0;
        tick();
        chk("rst2_storeerr", {31'h0, StoreErr}, 32'h0);
        chk("rst2_memdata", MemData, 32'h0);
        nReset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_clear_busy", {31'h0, Busy}, 32'h1);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        chk("restart_busy", {31'h0, Busy}, 32'h1);
        wait_clear("restart_len");

        load(16'h0030, 32'h0000_0000, "recleared");
        store(16'h0040, 32'hCAFE_F00D, 1'b0, 1'b0);
        load(16'h0000, 32'hCAFE_F00D, "alias_word0");
        DbgAddr = 16'h0040;
        tick();
        chk("dbg_alias", DbgData, 32'hCAFE_F00D);

        tick(); tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Synchronous data RAM directly downstream of the processor memory stage.
- Consumes MemAddr, WriteData, MemWrite, MemRead, WriteL and WriteR from the processor.
- Returns MemData one clock later, which is when the writeback stage samples it.
- Performs byte-lane merging for full-word, store-word-left and store-word-right stores, runs a post-reset clear sequence, and provides an independent registered debug read port.

Parameters:
DEPTH_WORDS, 16384, number of 32-bit words; index = MemAddr[15:2] modulo DEPTH_WORDS (power of two, 16..16384).
CLEAR_ON_RESET, 1, 1 = zero all words after reset via the clear FSM; 0 = skip straight to READY, contents untouched.

Ports:
Clock      input   1   rising-edge clock
nReset     input   1   synchronous active-low reset, sampled on rising Clock
MemAddr    input   16  byte address of the access
WriteData  input   32  store data as aligned by the processor MEM stage
MemWrite   input   1   store request this cycle
MemRead    input   1   load request this cycle
WriteL     input   1   store-word-left select
WriteR     input   1   store-word-right select
MemData    output  32  registered read word
DbgAddr    input   16  debug byte address
DbgData    output  32  registered debug read word
Busy       output  1   high while the clear FSM runs; accesses are ignored
StoreErr   output  1   sticky; set by an illegal store

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low.
  - On a rising Clock edge with nReset=0: MemData=0, DbgData=0, StoreErr=0, clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else to READY; Busy=1 in CLEAR and 0 in READY.
  - Array contents are not changed by reset itself.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to word[cnt], then cnt increments.
  - When cnt = DEPTH_WORDS-1 has been written, the next state is READY.
  - Duration is exactly DEPTH_WORDS cycles after reset deassertion; Busy drops on the edge that enters READY.
  - MemRead and MemWrite are ignored; MemData holds 0.
  - DbgData still updates and may show partially cleared contents.
  - Reset asserted mid-CLEAR restarts the sequence at cnt=0.
- READY: no exit except reset.
- Addressing: word index W = MemAddr[15:2] mod DEPTH_WORDS; o = MemAddr[1:0]. Lane numbering is big-endian: lane0 = bits[31:24] ... lane3 = bits[7:0].
- Store, sampled at the rising edge when READY and MemWrite=1:
  - WriteL=0, WriteR=0: full word; all lanes written with WriteData; o ignored.
  - WriteL=1, WriteR=0 (SWL): lanes o..3 written with WriteData lanes 0..3-o; lanes 0..o-1 keep old value.
  - WriteL=0, WriteR=1 (SWR): lanes 0..o written with WriteData lanes 3-o..3; lanes o+1..3 keep old value.
  - WriteL=1, WriteR=1: illegal; no write; StoreErr set to 1 and held until reset.
  - WriteL/WriteR with MemWrite=0: no effect.
- Load: when READY and MemRead=1, MemData at the next edge = the full word W. There is no lane extraction; writeback does alignment.
  - MemRead=0: MemData holds its previous value.
  - Load latency is exactly 1 cycle.
- Simultaneous events:
  - Read and write to the same W in one cycle: MemData returns the pre-write word (read-before-write). The new data is visible to a read issued in the following cycle.
  - MemRead and MemWrite both high to different words: both performed.
  - Debug read of a word being written that cycle also returns the old word.
- Debug port: DbgData at the next edge = word[DbgAddr[15:2] mod DEPTH_WORDS], every cycle, in any state except reset. It has no side effects.
- Out-of-range addresses wrap by modulo. There are no error or trap outputs besides StoreErr.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH_WORDS=16: Busy=1 for exactly 16 cycles after nReset rises, then 0. A load from 0x0008 then gives MemData=0x00000000. A store issued during Busy is discarded: a load from that word afterward returns 0.
- Full store 0x11223344 to 0x0004, then load from 0x0006 -> MemData=0x11223344 one cycle after the load cycle; holds while MemRead=0.
- Word 0x0010 = 0xAABBCCDD:
  - SWL at 0x0011 with WriteData 0x11223344 -> 0xAA112233.
  - SWR at 0x0012 with WriteData 0x55667788 -> 0x66778833 (word 0xAA112233 after the SWL).
- Same-cycle store 0xDEADBEEF and load to word 0x0020 (previous 0x00000005) -> MemData=0x00000005; the next-cycle load returns 0xDEADBEEF; DbgAddr=0x0020 shows 0xDEADBEEF.
- MemWrite=1 with WriteL=WriteR=1 to 0x0030 -> word unchanged, StoreErr=1. StoreErr stays 1 through later legal stores and clears only on reset.
- Reset asserted at cycle 5 of CLEAR -> Busy stays 1 and the full 16-cycle clear restarts. A store to 0x0040 (maps to word 0) with DEPTH_WORDS=16 aliases word 0, and a load from 0x0000 returns it.
